// File: rtl/pd_cap_pkg.sv
// Shared types and encodings for the debug-watcher capture controller.
// Imported by the trigger matcher and the capture FSM.
package pd_cap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_WAIT = 3'd2,
      ST_POST = 3'd3,
      ST_DONE = 3'd4
   } cap_state_e;

   localparam logic MODE_AND = 1'b0;
   localparam logic MODE_OR  = 1'b1;

   localparam logic EDGE_LVL = 1'b0;
   localparam logic EDGE_EDG = 1'b1;

   function automatic logic state_is_busy(input cap_state_e s);
      return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/pd_capture_ctrl_if.sv
// Write port toward the circular capture RAM; the controller drives it as master,
// the RAM (or its wrapper) receives it as slave.
interface pd_capture_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int CH_NUM = 8
);

   logic              wt_ce;
   logic              wt_en;
   logic [ADDR_W-1:0] wt_addr;
   logic [CH_NUM-1:0] wt_data;

   modport master (
      output wt_ce,
      output wt_en,
      output wt_addr,
      output wt_data
   );

   modport slave (
      input wt_ce,
      input wt_en,
      input wt_addr,
      input wt_data
   );

endinterface

// File: rtl/pd_cap_trig_match.sv
// Per-channel level/edge compare and AND/OR combine over the masked channels.
// Purely combinational; prev_i is the sample registered on the previous cycle.
module pd_cap_trig_match
   import pd_cap_pkg::*;
#(
   parameter int CH_NUM = 8
) (
   input  logic [CH_NUM-1:0] din_i,
   input  logic [CH_NUM-1:0] prev_i,
   input  logic [CH_NUM-1:0] mask_i,
   input  logic [CH_NUM-1:0] val_i,
   input  logic [CH_NUM-1:0] edge_i,
   input  logic              mode_i,
   output logic              match_o
);

   logic [CH_NUM-1:0] ch_hit;

   always_comb begin
      // NOTE: default every bit first so no path through the loop can leave a latch.
      ch_hit = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (din_i[i] == val_i[i]) begin
            ch_hit[i] = (edge_i[i] == EDGE_LVL) || (din_i[i] != prev_i[i]);
         end
      end
   end

   // Unmasked channels are neutral: forced true for AND, forced false for OR.
   assign match_o = (mode_i == MODE_OR) ? |(ch_hit & mask_i)
                                        : &(ch_hit | ~mask_i);

endmodule

// File: rtl/pd_capture_ctrl.sv
// Capture controller: generates circular-buffer write strobes around a trigger
// event with a configurable pre-trigger window and Nth-occurrence triggering.
module pd_capture_ctrl
   import pd_cap_pkg::*;
#(
   parameter int CH_NUM = 8,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 8
) (
   input  logic              trig_clk,
   input  logic              jrstn,
   input  logic              arm,
   input  logic              abort,
   input  logic [CH_NUM-1:0] din,
   input  logic [CH_NUM-1:0] trig_mask,
   input  logic [CH_NUM-1:0] trig_val,
   input  logic [CH_NUM-1:0] trig_edge,
   input  logic              trig_mode,
   input  logic [CNT_W-1:0]  trig_count,
   input  logic [ADDR_W-1:0] pre_len,
   pd_capture_ctrl_if.master wr,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              busy,
   output logic              triggered,
   output logic              done
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   cap_state_e        state_q;
   logic [ADDR_W-1:0] nxt_addr_q;
   logic [ADDR_W-1:0] post_cnt_q;
   logic [ADDR_W-1:0] wt_addr_q;
   logic [CH_NUM-1:0] wt_data_q;
   logic              wt_en_q;
   logic [ADDR_W-1:0] trig_addr_q;
   logic              triggered_q;
   logic              done_q;
   logic [CNT_W-1:0]  match_cnt_q;

   logic              samp_match;
   logic [CNT_W:0]    match_cnt_inc;
   logic [CNT_W:0]    match_target;
   logic              trig_hit;
   logic              start_cap;

   pd_cap_trig_match #(
      .CH_NUM (CH_NUM)
   ) u_match (
      .din_i   (din),
      .prev_i  (wt_data_q),
      .mask_i  (trig_mask),
      .val_i   (trig_val),
      .edge_i  (trig_edge),
      .mode_i  (trig_mode),
      .match_o (samp_match)
   );

   // A trig_count of zero behaves like one.
   assign match_cnt_inc = {1'b0, match_cnt_q} + 1'b1;
   assign match_target  = (trig_count == '0) ? (CNT_W+1)'(1) : {1'b0, trig_count};
   assign trig_hit      = samp_match && (match_cnt_inc >= match_target);

   // Abort has priority over arm; arm is only honoured when not capturing.
   assign start_cap = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_ff @(posedge trig_clk or negedge jrstn) begin
      if (!jrstn) begin
         state_q     <= ST_IDLE;
         nxt_addr_q  <= '0;
         post_cnt_q  <= '0;
         wt_addr_q   <= '0;
         wt_data_q   <= '0;
         wt_en_q     <= 1'b0;
         trig_addr_q <= '0;
         triggered_q <= 1'b0;
         done_q      <= 1'b0;
         match_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking throughout so every register sees pre-edge values.
         wt_data_q <= din;

         if (abort && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            wt_en_q <= 1'b0;
         end else if (start_cap) begin
            state_q     <= (pre_len == '0) ? ST_WAIT : ST_PRE;
            nxt_addr_q  <= '0;
            wt_addr_q   <= '0;
            wt_en_q     <= 1'b0;
            match_cnt_q <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  wt_en_q <= 1'b0;
               end

               ST_PRE: begin
                  wt_en_q    <= 1'b1;
                  wt_addr_q  <= nxt_addr_q;
                  nxt_addr_q <= nxt_addr_q + 1'b1;
                  if (nxt_addr_q == pre_len - 1'b1) begin
                     state_q <= ST_WAIT;
                  end
               end

               ST_WAIT: begin
                  wt_en_q    <= 1'b1;
                  wt_addr_q  <= nxt_addr_q;
                  nxt_addr_q <= nxt_addr_q + 1'b1;
                  if (trig_hit) begin
                     trig_addr_q <= nxt_addr_q;
                     triggered_q <= 1'b1;
                     post_cnt_q  <= ADDR_MAX - pre_len;
                     state_q     <= ST_POST;
                  end else if (samp_match) begin
                     match_cnt_q <= match_cnt_inc[CNT_W-1:0];
                  end
               end

               ST_POST: begin
                  wt_en_q    <= 1'b1;
                  wt_addr_q  <= nxt_addr_q;
                  nxt_addr_q <= nxt_addr_q + 1'b1;
                  post_cnt_q <= post_cnt_q - 1'b1;
                  if (post_cnt_q == ADDR_W'(1)) begin
                     state_q <= ST_DONE;
                  end
               end

               ST_DONE: begin
                  wt_en_q <= 1'b0;
                  done_q  <= 1'b1;
               end

               default: begin
                  state_q <= ST_IDLE;
                  wt_en_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign wr.wt_ce   = wt_en_q;
   assign wr.wt_en   = wt_en_q;
   assign wr.wt_addr = wt_addr_q;
   assign wr.wt_data = wt_data_q;

   assign trig_addr = trig_addr_q;
   assign triggered = triggered_q;
   assign done      = done_q;
   assign busy      = state_is_busy(state_q);

endmodule

// File: tb/tb_pd_capture_ctrl.sv
// Self-checking bench for pd_capture_ctrl: directed scenarios plus randomized
// captures, each compared cycle by cycle against a sample-indexed model.
module tb_pd_capture_ctrl;

   localparam int CH_NUM = 8;
   localparam int ADDR_W = 4;
   localparam int CNT_W  = 8;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int NSTIM  = 128;

   logic              trig_clk = 1'b0;
   logic              jrstn    = 1'b0;
   logic              arm      = 1'b0;
   logic              abort    = 1'b0;
   logic [CH_NUM-1:0] din       = '0;
   logic [CH_NUM-1:0] trig_mask = '0;
   logic [CH_NUM-1:0] trig_val  = '0;
   logic [CH_NUM-1:0] trig_edge = '0;
   logic              trig_mode = 1'b0;
   logic [CNT_W-1:0]  trig_count = '0;
   logic [ADDR_W-1:0] pre_len   = '0;
   logic [ADDR_W-1:0] trig_addr;
   logic              busy;
   logic              triggered;
   logic              done;

   pd_capture_ctrl_if #(.ADDR_W(ADDR_W), .CH_NUM(CH_NUM)) wr ();

   pd_capture_ctrl #(
      .CH_NUM (CH_NUM),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .trig_clk   (trig_clk),
      .jrstn      (jrstn),
      .arm        (arm),
      .abort      (abort),
      .din        (din),
      .trig_mask  (trig_mask),
      .trig_val   (trig_val),
      .trig_edge  (trig_edge),
      .trig_mode  (trig_mode),
      .trig_count (trig_count),
      .pre_len    (pre_len),
      .wr         (wr),
      .trig_addr  (trig_addr),
      .busy       (busy),
      .triggered  (triggered),
      .done       (done)
   );

   always #5 trig_clk = ~trig_clk;

   int checks = 0;
   int errors = 0;

   logic [CH_NUM-1:0] stim [NSTIM];
   logic [CH_NUM-1:0] din_arm;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Spec-level channel rule: level = din==val; edge additionally needs din!=prev.
   function automatic bit sample_matches(input logic [CH_NUM-1:0] s, input logic [CH_NUM-1:0] p);
      bit any_hit = 1'b0;
      bit all_hit = 1'b1;
      for (int c = 0; c < CH_NUM; c++) begin
         if (trig_mask[c]) begin
            bit hit = (s[c] == trig_val[c]) && (!trig_edge[c] || (s[c] != p[c]));
            any_hit |= hit;
            all_hit &= hit;
         end
      end
      return trig_mode ? any_hit : all_hit;
   endfunction

   task automatic fill_random_stim();
      for (int j = 0; j < NSTIM; j++) stim[j] = CH_NUM'($urandom);
      din_arm = CH_NUM'($urandom);
   endtask

   // Sample j is stim[j], written at address j mod DEPTH, visible at observation j+1.
   task automatic run_capture(input string name, input int abort_at, input bit rearm_in_post,
                              output int t_out);
      int t = -1;
      int a = abort_at;
      int lim;
      int cnt = 0;
      int target;
      int w;
      int n_obs;
      int rearm_at = -1;
      int writes = 0;
      logic [CH_NUM-1:0] prev;
      bit exp_en;

      target = (trig_count == 0) ? 1 : int'(trig_count);
      lim    = (a > 0) ? a - 1 : 78;
      for (int j = int'(pre_len); j < lim; j++) begin
         prev = (j == 0) ? din_arm : stim[j-1];
         if (sample_matches(stim[j], prev)) begin
            cnt++;
            if (cnt == target) begin
               t = j;
               break;
            end
         end
      end
      if (t >= 0) a = 0;
      else if (a == 0) a = 79;
      w     = (t >= 0) ? t + DEPTH - int'(pre_len) : 1000000;
      n_obs = (t >= 0) ? w + 2 : a + 2;
      if (rearm_in_post && t >= 0) rearm_at = t + 3;

      @(negedge trig_clk);
      din   = din_arm;
      arm   = 1'b1;
      abort = 1'b0;
      for (int i = 0; i <= n_obs; i++) begin
         @(negedge trig_clk);
         exp_en = (i >= 1) && (i <= w) && (a == 0 || i < a);
         check($sformatf("%s.wt_en[%0d]", name, i), wr.wt_en, exp_en);
         check($sformatf("%s.wt_ce[%0d]", name, i), wr.wt_ce, exp_en);
         if (exp_en) begin
            check($sformatf("%s.wt_addr[%0d]", name, i), wr.wt_addr, (i - 1) % DEPTH);
            check($sformatf("%s.wt_data[%0d]", name, i), wr.wt_data, stim[i-1]);
         end
         check($sformatf("%s.triggered[%0d]", name, i), triggered, (t >= 0) && (i >= t + 1));
         check($sformatf("%s.done[%0d]", name, i), done, (t >= 0) && (i >= w + 1));
         check($sformatf("%s.busy[%0d]", name, i), busy, (i < w) && (a == 0 || i < a));
         writes += int'(wr.wt_en);
         din   = stim[i];
         arm   = (i == rearm_at);
         abort = (a > 0) && (i == a - 1);
      end
      arm   = 1'b0;
      abort = 1'b0;
      check($sformatf("%s.n_writes", name), writes, (t >= 0) ? w : a - 1);
      if (t >= 0) check($sformatf("%s.trig_addr", name), trig_addr, t % DEPTH);
      t_out = t;
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".wt_en"},     wr.wt_en,   0);
      check({name, ".wt_ce"},     wr.wt_ce,   0);
      check({name, ".wt_addr"},   wr.wt_addr, 0);
      check({name, ".wt_data"},   wr.wt_data, 0);
      check({name, ".trig_addr"}, trig_addr,  0);
      check({name, ".busy"},      busy,       0);
      check({name, ".triggered"}, triggered,  0);
      check({name, ".done"},      done,       0);
   endtask

   initial begin
      int t;

      din = CH_NUM'($urandom);
      repeat (2) @(negedge trig_clk);
      check_all_zero("reset");
      jrstn = 1'b1;
      repeat (2) @(negedge trig_clk);

      // Level trigger on ch0 at the 10th sample, four pre-trigger samples.
      fill_random_stim();
      for (int j = 0; j < 9; j++) stim[j][0] = 1'b0;
      stim[9][0] = 1'b1;
      trig_mask = 8'h01; trig_val = 8'h01; trig_edge = 8'h00;
      trig_mode = 1'b0; trig_count = 8'd1; pre_len = 4'd4;
      run_capture("lvl", 0, 1'b0, t);
      check("lvl.trig_addr_is_9", trig_addr, 9);

      // Rising edge on ch2, third occurrence; ch2 stays high for three samples per pulse.
      fill_random_stim();
      for (int j = 0; j < NSTIM; j++) stim[j][2] = ((j % 5) >= 2);
      din_arm[2] = 1'b0;
      trig_mask = 8'h04; trig_val = 8'h04; trig_edge = 8'h04;
      trig_mode = 1'b0; trig_count = 8'd3; pre_len = 4'd1;
      run_capture("edge3", 0, 1'b0, t);
      check("edge3.third_rise_sample", t, 12);

      // OR with empty mask never triggers; abort ends the capture.
      fill_random_stim();
      trig_mask = 8'h00; trig_mode = 1'b1; trig_count = 8'd1; pre_len = 4'd2;
      run_capture("or_abort", 30, 1'b0, t);

      // arm and abort together from IDLE: no capture starts.
      @(negedge trig_clk);
      arm = 1'b1; abort = 1'b1;
      @(negedge trig_clk);
      arm = 1'b0; abort = 1'b0;
      check("arm_abort.busy", busy, 0);
      check("arm_abort.wt_en", wr.wt_en, 0);
      check("arm_abort.done", done, 0);
      @(negedge trig_clk);
      check("arm_abort.busy_later", busy, 0);

      // No pre-trigger, count 0, AND over empty mask: trigger on the first sample.
      fill_random_stim();
      trig_mask = 8'h00; trig_mode = 1'b0; trig_count = 8'd0; pre_len = 4'd0;
      run_capture("first", 0, 1'b0, t);
      check("first.trig_sample", t, 0);

      // arm pulse in POST is ignored.
      fill_random_stim();
      trig_mask = 8'h02; trig_val = 8'h02; trig_edge = 8'h00;
      trig_mode = 1'b0; trig_count = 8'd1; pre_len = 4'd3;
      run_capture("rearm", 0, 1'b1, t);

      // Reset in the middle of POST, then a clean capture.
      fill_random_stim();
      trig_mask = 8'h00; trig_mode = 1'b0; trig_count = 8'd0; pre_len = 4'd0;
      @(negedge trig_clk);
      arm = 1'b1;
      @(negedge trig_clk);
      arm = 1'b0;
      repeat (6) @(negedge trig_clk);
      check("pre_rst.busy", busy, 1);
      @(posedge trig_clk);
      #2 jrstn = 1'b0;
      #1 check_all_zero("mid_rst");
      @(negedge trig_clk);
      jrstn = 1'b1;
      run_capture("post_rst", 0, 1'b0, t);

      for (int r = 0; r < 6; r++) begin
         fill_random_stim();
         trig_mask  = CH_NUM'(1 << $urandom_range(0, CH_NUM - 1));
         if ($urandom_range(0, 1) == 1) trig_mask |= CH_NUM'(1 << $urandom_range(0, CH_NUM - 1));
         trig_val   = CH_NUM'($urandom);
         trig_edge  = CH_NUM'($urandom);
         trig_mode  = 1'($urandom_range(0, 1));
         trig_count = CNT_W'($urandom_range(0, 3));
         pre_len    = ADDR_W'($urandom_range(0, DEPTH - 2));
         run_capture($sformatf("rnd%0d", r), 0, 1'b0, t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
